tx_block_gen: RTL and testbench



---
 rtl/tx_block_gen.sv | 183 ++++++++++++++++++
 tb/tb_tx_block_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_block_gen.sv
// ---------------------------------------------------------------------------
// tx_block_gen_pkg / tx_block_gen
//
// TX block generator for a simplex Aurora 64B/66B lane. It sits directly
// downstream of channel init and feeds the TX gearbox.
//  - During init it turns the requested ordered set (SP / I / VER) into
//    66-bit control blocks. While in I, a channel-bonding flag is set on
//    every CB_PERIOD-th consecutive I block.
//  - After init_finished it passes user words through as data blocks.
//  - In every state it periodically inserts a burst of CC_LEN
//    clock-compensation blocks, once every CC_PERIOD ordinary blocks.
//
// Ports
//  clk            in   clock
//  rst            in   asynchronous, active-high reset
//  ordered_sets   in   one-hot {sp, i, ver} request; priority VER > I > SP
//  init_finished  in   channel up, user data enabled
//  gb_ready       in   gearbox takes a block this cycle (low = pause)
//  tx_data        in   64-bit user word
//  tx_valid       in   tx_data valid
//  tx_ready       out  user word accepted when tx_valid & tx_ready
//  block_header   out  sync header, 2'b01 data / 2'b10 control
//  block_data     out  64-bit block payload
//  block_valid    out  block_header / block_data valid this cycle
// ---------------------------------------------------------------------------
package tx_block_gen_pkg;

  typedef struct packed {
    logic sp;
    logic i;
    logic ver;
  } ordered_sets_t;

  localparam logic [1:0] HDR_DATA  = 2'b01;
  localparam logic [1:0] HDR_CTRL  = 2'b10;
  localparam logic [7:0] IDLE_TYPE = 8'h78;

  // Control payload: idle type, then the CC/CB/NR/VER flags, rest zero.
  function automatic logic [63:0] ctrl_payload(input logic cc, input logic cb,
                                               input logic nr, input logic ver);
    return {IDLE_TYPE, cc, cb, nr, ver, 52'h0};
  endfunction

endpackage

module tx_block_gen
  import tx_block_gen_pkg::*;
#(
  parameter int CC_PERIOD = 5000,
  parameter int CC_LEN    = 3,
  parameter int CB_PERIOD = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  ordered_sets_t ordered_sets,
  input  logic          init_finished,
  input  logic          gb_ready,
  input  logic [63:0]   tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [1:0]    block_header,
  output logic [63:0]   block_data,
  output logic          block_valid
);

  localparam int CC_W  = $clog2(CC_PERIOD + 1);
  localparam int LEN_W = $clog2(CC_LEN + 1);
  localparam int CB_W  = $clog2(CB_PERIOD + 1);

  localparam logic [CC_W-1:0]  CC_LAST  = CC_W'(CC_PERIOD - 1);
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(CC_LEN - 1);
  localparam logic [CB_W-1:0]  CB_LAST  = CB_W'(CB_PERIOD - 1);

  logic [1:0]       block_header_q, block_header_d;
  logic [63:0]      block_data_q,   block_data_d;
  logic             block_valid_q,  block_valid_d;
  logic [CC_W-1:0]  cc_cnt_q,       cc_cnt_d;
  logic [LEN_W-1:0] len_cnt_q,      len_cnt_d;
  logic [CB_W-1:0]  cb_cnt_q,       cb_cnt_d;
  logic             cc_active_q,    cc_active_d;

  // Per-step block selection.
  logic is_data;
  logic f_cc, f_cb, f_nr, f_ver;

  // Words are only taken on steps that will emit them, so a CC burst or a
  // gearbox pause can never drop user data.
  assign tx_ready = gb_ready & init_finished & ~cc_active_q;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    block_header_d = block_header_q;
    block_data_d   = block_data_q;
    block_valid_d  = 1'b0;
    cc_cnt_d       = cc_cnt_q;
    len_cnt_d      = len_cnt_q;
    cb_cnt_d       = cb_cnt_q;
    cc_active_d    = cc_active_q;
    is_data        = 1'b0;
    f_cc           = 1'b0;
    f_cb           = 1'b0;
    f_nr           = 1'b0;
    f_ver          = 1'b0;

    if (gb_ready) begin
      block_valid_d = 1'b1;
      // Any step that is not an I block breaks the bonding run.
      cb_cnt_d      = '0;

      if (cc_active_q) begin
        // A started burst always runs to completion, even if init drops.
        f_cc = 1'b1;
        f_nr = ~init_finished;
        if (len_cnt_q == LEN_LAST) begin
          cc_active_d = 1'b0;
          len_cnt_d   = '0;
        end else begin
          len_cnt_d = len_cnt_q + 1'b1;
        end
      end else begin
        // The step that hits the period boundary is still an ordinary
        // block; the burst begins on the following step.
        if (cc_cnt_q == CC_LAST) begin
          cc_cnt_d    = '0;
          cc_active_d = 1'b1;
          len_cnt_d   = '0;
        end else begin
          cc_cnt_d = cc_cnt_q + 1'b1;
        end

        if (!init_finished) begin
          if (ordered_sets.ver) begin
            f_ver = 1'b1;
          end else if (ordered_sets.i) begin
            f_cb     = (cb_cnt_q == CB_LAST);
            cb_cnt_d = f_cb ? '0 : cb_cnt_q + 1'b1;
          end else begin
            // SP and "nothing requested" both send not-ready idles.
            f_nr = 1'b1;
          end
        end else if (tx_valid) begin
          is_data = 1'b1;
        end
      end

      if (is_data) begin
        block_header_d = HDR_DATA;
        block_data_d   = tx_data;
      end else begin
        block_header_d = HDR_CTRL;
        block_data_d   = ctrl_payload(f_cc, f_cb, f_nr, f_ver);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block_header_q <= HDR_CTRL;
      block_data_q   <= ctrl_payload(1'b0, 1'b0, 1'b1, 1'b0);
      block_valid_q  <= 1'b0;
      cc_cnt_q       <= '0;
      len_cnt_q      <= '0;
      cb_cnt_q       <= '0;
      cc_active_q    <= 1'b0;
    end else begin
      block_header_q <= block_header_d;
      block_data_q   <= block_data_d;
      block_valid_q  <= block_valid_d;
      cc_cnt_q       <= cc_cnt_d;
      len_cnt_q      <= len_cnt_d;
      cb_cnt_q       <= cb_cnt_d;
      cc_active_q    <= cc_active_d;
    end
  end

  assign block_header = block_header_q;
  assign block_data   = block_data_q;
  assign block_valid  = block_valid_q;

endmodule

// File: tb/tb_tx_block_gen.sv
// ---------------------------------------------------------------------------
// tb_tx_block_gen
//
// Scoreboard bench for tx_block_gen with short CC / CB periods. The driver
// applies stimulus on the falling edge, asks a behavioural model what block
// the next rising edge must produce and queues it; a separate monitor pops
// and compares every block the DUT presents, and checks that outputs hold
// while block_valid is low.
// ---------------------------------------------------------------------------
module tb_tx_block_gen;
  import tx_block_gen_pkg::*;

  localparam int CC_PERIOD = 8;
  localparam int CC_LEN    = 3;
  localparam int CB_PERIOD = 4;

  typedef struct packed {
    logic [1:0]  hdr;
    logic [63:0] data;
  } blk_t;

  logic          clk = 1'b0;
  logic          rst;
  ordered_sets_t ordered_sets;
  logic          init_finished;
  logic          gb_ready;
  logic [63:0]   tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [1:0]    block_header;
  logic [63:0]   block_data;
  logic          block_valid;

  tx_block_gen #(
    .CC_PERIOD(CC_PERIOD),
    .CC_LEN   (CC_LEN),
    .CB_PERIOD(CB_PERIOD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ordered_sets (ordered_sets),
    .init_finished(init_finished),
    .gb_ready     (gb_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .block_header (block_header),
    .block_data   (block_data),
    .block_valid  (block_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  blk_t exp_q[$];
  blk_t last_blk;

  // Reference model state, in terms of counted blocks rather than registers.
  int normal_steps;  // ordinary blocks since the last burst ended
  int cc_left;       // CC blocks still owed in the current burst
  int i_run;         // length of the current run of consecutive I blocks

  localparam ordered_sets_t OS_SP  = '{sp: 1'b1, i: 1'b0, ver: 1'b0};
  localparam ordered_sets_t OS_I   = '{sp: 1'b0, i: 1'b1, ver: 1'b0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic blk_t ctrl(input bit cc, input bit cb, input bit nr, input bit ver);
    blk_t b;
    b.hdr  = 2'b10;
    b.data = 64'h7800_0000_0000_0000 | ({60'h0, cc, cb, nr, ver} << 52);
    return b;
  endfunction

  function automatic blk_t reset_blk();
    return ctrl(0, 0, 1, 0);
  endfunction

  task automatic model_reset();
    normal_steps = 0;
    cc_left      = 0;
    i_run        = 0;
    exp_q.delete();
    last_blk = reset_blk();
  endtask

  // One gearbox step: decide the block from the rules and queue it.
  task automatic model_step(input ordered_sets_t os, input logic init,
                            input logic valid, input logic [63:0] data);
    blk_t b;
    if (cc_left > 0) begin
      b = ctrl(1, 0, !init, 0);
      cc_left--;
      i_run = 0;
    end else begin
      normal_steps++;
      if (!init && !os.ver && os.i) begin
        i_run++;
        b = ctrl(0, (i_run % CB_PERIOD) == 0, 0, 0);
      end else begin
        i_run = 0;
        if (!init)      b = os.ver ? ctrl(0, 0, 0, 1) : ctrl(0, 0, 1, 0);
        else if (valid) b = '{hdr: 2'b01, data: data};
        else            b = ctrl(0, 0, 0, 0);
      end
      if (normal_steps == CC_PERIOD) begin
        normal_steps = 0;
        cc_left      = CC_LEN;
      end
    end
    exp_q.push_back(b);
  endtask

  // Drive one cycle of inputs on the falling edge and predict its outcome.
  task automatic cycle(input logic gb, input logic init, input ordered_sets_t os,
                       input logic valid, input logic [63:0] data);
    @(negedge clk);
    gb_ready      = gb;
    init_finished = init;
    ordered_sets  = os;
    tx_valid      = valid;
    tx_data       = data;
    #1;
    check("tx_ready", {63'h0, tx_ready}, {63'h0, gb & init & (cc_left == 0)});
    if (gb) model_step(os, init, valid, data);
  endtask

  // Asynchronous reset pulse placed away from any clock edge.
  task automatic pulse_reset();
    @(negedge clk);
    #2;
    gb_ready = 1'b0;
    rst      = 1'b1;
    #1;
    model_reset();
    check("rst_header", {62'h0, block_header}, {62'h0, 2'b10});
    check("rst_data",   block_data, 64'h7820_0000_0000_0000);
    check("rst_valid",  {63'h0, block_valid}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Monitor: every presented block must match the head of the queue; with
  // block_valid low the outputs must still show the last block.
  initial begin
    blk_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (block_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL extra_block: got %b/%h, expected no block", block_header, block_data);
          end else begin
            e = exp_q.pop_front();
            check("block_header", {62'h0, block_header}, {62'h0, e.hdr});
            check("block_data", block_data, e.data);
            last_blk = e;
          end
        end else begin
          check("hold_header", {62'h0, block_header}, {62'h0, last_blk.hdr});
          check("hold_data", block_data, last_blk.data);
        end
      end
    end
  end

  initial begin
    int guard;
    logic init_r;
    rst           = 1'b1;
    gb_ready      = 1'b0;
    init_finished = 1'b0;
    ordered_sets  = OS_SP;
    tx_valid      = 1'b0;
    tx_data       = '0;
    model_reset();
    #12;
    check("por_header", {62'h0, block_header}, {62'h0, 2'b10});
    check("por_data",   block_data, 64'h7820_0000_0000_0000);
    check("por_valid",  {63'h0, block_valid}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // SP during init: not-ready idles every cycle, CC burst included.
    for (int k = 0; k < 14; k++) cycle(1, 0, OS_SP, 0, '0);

    // I run from a fresh reset: CB on every fourth I block.
    pulse_reset();
    for (int k = 0; k < 16; k++) cycle(1, 0, OS_I, 0, '0);

    // Constant data with the gearbox pausing every other cycle.
    for (int k = 0; k < 24; k++) cycle(k[0] == 1'b0, 1, OS_SP, 1, 64'h0123_4567_89AB_CDEF);

    // Continuous random data through several CC bursts.
    pulse_reset();
    for (int k = 0; k < 30; k++) cycle(1, 1, OS_SP, 1, rand64());

    // Gearbox pause right on the second CC step of a burst.
    guard = 0;
    while (cc_left != CC_LEN - 1 && guard < 40) begin
      cycle(1, 1, OS_SP, 1, rand64());
      guard++;
    end
    check("reach_burst", {63'h0, cc_left == CC_LEN - 1}, 64'h1);
    cycle(0, 1, OS_SP, 1, rand64());
    for (int k = 0; k < 6; k++) cycle(1, 1, OS_SP, 1, rand64());

    // Reset in the middle of a burst; the schedule must restart from zero.
    guard = 0;
    while (cc_left != 1 && guard < 40) begin
      cycle(1, 1, OS_SP, 1, rand64());
      guard++;
    end
    check("reach_mid_burst", {63'h0, cc_left == 1}, 64'h1);
    pulse_reset();
    for (int k = 0; k < 12; k++) cycle(1, 1, OS_SP, 1, rand64());

    // Random traffic: overlapping ordered-set bits, init toggling, pauses.
    init_r = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) init_r = ~init_r;
      cycle($urandom_range(0, 3) != 0, init_r, ordered_sets_t'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, rand64());
    end

    @(negedge clk);
    gb_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
